// File: rtl/cs_slice_sequencer.sv
// Control-store access sequencer: splits one 64-bit microinstruction read or
// write into four 16-bit slice accesses on the CS control interface.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for START; slice counter held at 0
// S_W_SETUP  | drive slice data on IDB, strobe still high
// S_W_STROBE | WCS_n low for STROBE_LEN cycles
// S_W_HOLD   | strobe released, data held; advance slice or finish
// S_R_ENABLE | LCS_n low, control store drives IDB
// S_R_SAMPLE | LCS_n low; IDB_IN captured into shadow on exit
// S_FIN      | DONE pulse; read result committed to RDATA on exit

module cs_slice_sequencer #(
   parameter int STROBE_LEN = 1
) (
   input  logic        sysclk,
   input  logic        sys_rst_n,
   input  logic        START,
   input  logic        WRITE,
   input  logic [12:0] ADDR,
   input  logic [63:0] WDATA,
   input  logic [15:0] IDB_IN,
   output logic [12:0] LUA,
   output logic [1:0]  RF_1_0,
   output logic        WCS_n,
   output logic        LCS_n,
   output logic [15:0] IDB_OUT,
   output logic        IDB_OE,
   output logic [63:0] RDATA,
   output logic        BUSY,
   output logic        DONE
);

   if (STROBE_LEN < 1 || STROBE_LEN > 4) begin : g_bad_strobe_len
      $error("cs_slice_sequencer: STROBE_LEN must be in 1..4");
   end

   localparam logic [1:0] STRB_LOAD = 2'(STROBE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_SETUP  = 3'd1,
      S_W_STROBE = 3'd2,
      S_W_HOLD   = 3'd3,
      S_R_ENABLE = 3'd4,
      S_R_SAMPLE = 3'd5,
      S_FIN      = 3'd6
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  slice;
   logic [1:0]  strb_cnt;
   logic [12:0] lua_q;
   logic [63:0] wdata_q;
   logic        write_q;
   logic [63:0] shadow;
   logic [63:0] rdata_q;
   logic        drive_idb;

   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (START) begin
               state_nxt = WRITE ? S_W_SETUP : S_R_ENABLE;
            end
         end
         S_W_SETUP:  state_nxt = S_W_STROBE;
         S_W_STROBE: begin
            if (strb_cnt == 2'd0) begin
               state_nxt = S_W_HOLD;
            end
         end
         S_W_HOLD:   state_nxt = (slice == 2'd3) ? S_FIN : S_W_SETUP;
         S_R_ENABLE: state_nxt = S_R_SAMPLE;
         S_R_SAMPLE: state_nxt = (slice == 2'd3) ? S_FIN : S_R_ENABLE;
         S_FIN:      state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Strobe-length timer is a down-counter loaded in setup; terminal count 0
   // ends the strobe, so WCS_n stays low exactly STROBE_LEN cycles.
   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         slice    <= 2'd0;
         strb_cnt <= 2'd0;
         lua_q    <= 13'd0;
         wdata_q  <= 64'd0;
         write_q  <= 1'b0;
         shadow   <= 64'd0;
         rdata_q  <= 64'd0;
      end else begin
         case (state)
            S_IDLE: begin
               slice <= 2'd0;
               if (START) begin
                  lua_q   <= ADDR;
                  wdata_q <= WDATA;
                  write_q <= WRITE;
               end
            end
            S_W_SETUP: begin
               strb_cnt <= STRB_LOAD;
            end
            S_W_STROBE: begin
               if (strb_cnt != 2'd0) begin
                  strb_cnt <= strb_cnt - 2'd1;
               end
            end
            S_W_HOLD: begin
               if (slice != 2'd3) begin
                  slice <= slice + 2'd1;
               end
            end
            S_R_SAMPLE: begin
               shadow[{slice, 4'b0000} +: 16] <= IDB_IN;
               if (slice != 2'd3) begin
                  slice <= slice + 2'd1;
               end
            end
            S_FIN: begin
               slice <= 2'd0;
               if (!write_q) begin
                  rdata_q <= shadow;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      drive_idb = (state == S_W_SETUP) || (state == S_W_STROBE) || (state == S_W_HOLD);
      BUSY      = (state != S_IDLE);
      DONE      = (state == S_FIN);
      WCS_n     = (state != S_W_STROBE);
      LCS_n     = !((state == S_R_ENABLE) || (state == S_R_SAMPLE));
      IDB_OE    = drive_idb;
      IDB_OUT   = drive_idb ? wdata_q[{slice, 4'b0000} +: 16] : 16'd0;
      RF_1_0    = slice;
      LUA       = lua_q;
      RDATA     = rdata_q;
   end

endmodule
